// File: rtl/matmul_pkg.sv
// Shared types and constants for the matrix-multiply sequencer and its MAC.
package matmul_pkg;

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WRITE, FIN} state_t;

  localparam int MAX_WIDTH_LEN = 2;
  localparam int SIZE_VALUE    = 8;

  // Wide enough for n full-scale signed products without overflow.
  function automatic int acc_width(input int sv, input int mw);
    return 2 * sv + mw;
  endfunction

  function automatic int sat_hi(input int sv);
    return (1 << (sv - 1)) - 1;
  endfunction

  function automatic int sat_lo(input int sv);
    return -(1 << (sv - 1));
  endfunction

  localparam int SAT_HI = sat_hi(SIZE_VALUE);
  localparam int SAT_LO = sat_lo(SIZE_VALUE);

endpackage

// File: rtl/matmul_mac.sv
// Signed multiply-accumulate with clear/enable; o_red is the reduced value of the
// next accumulator state (saturating when MATMUL_SATURATE_EN is defined, else wrapping).
module matmul_mac
  import matmul_pkg::*;
#(
  parameter int sizeValue = 8,
  parameter int accWidth  = acc_width(8, 2)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_clr,
  input  logic                        i_en,
  input  logic signed [sizeValue-1:0] i_a,
  input  logic signed [sizeValue-1:0] i_b,
  output logic signed [sizeValue-1:0] o_red
);

  logic signed [accWidth-1:0] r_acc;
  logic signed [accWidth-1:0] w_a;
  logic signed [accWidth-1:0] w_b;
  logic signed [accWidth-1:0] w_prod;
  logic signed [accWidth-1:0] w_sum;

  assign w_a    = accWidth'(i_a);
  assign w_b    = accWidth'(i_b);
  assign w_prod = w_a * w_b;
  assign w_sum  = r_acc + (i_en ? w_prod : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= w_sum;
    end
  end

`ifdef MATMUL_SATURATE_EN
  localparam logic signed [accWidth-1:0] SMAX = accWidth'(sat_hi(sizeValue));
  localparam logic signed [accWidth-1:0] SMIN = accWidth'(sat_lo(sizeValue));

  always_comb begin
    o_red = w_sum[sizeValue-1:0];
    if (w_sum > SMAX) begin
      o_red = SMAX[sizeValue-1:0];
    end else if (w_sum < SMIN) begin
      o_red = SMIN[sizeValue-1:0];
    end
  end
`else
  assign o_red = w_sum[sizeValue-1:0];
`endif

endmodule

// File: rtl/matmul_sequencer.sv
// C = A x B controller: walks i,j,k over synchronous-read A/B memories and writes C.
// Optional MATMUL_SATURATE_EN makes C elements saturate instead of wrap.
module matmul_sequencer
  import matmul_pkg::*;
#(
  parameter int maxWidthLen = 2,
  parameter int sizeValue   = 8,
  parameter int accWidth    = acc_width(sizeValue, maxWidthLen)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [maxWidthLen:0]          dim,
  output logic                          busy,
  output logic                          done,
  output logic [maxWidthLen-1:0]        a_x,
  output logic [maxWidthLen-1:0]        a_y,
  input  logic signed [sizeValue-1:0]   a_in,
  output logic [maxWidthLen-1:0]        b_x,
  output logic [maxWidthLen-1:0]        b_y,
  input  logic signed [sizeValue-1:0]   b_in,
  output logic [maxWidthLen-1:0]        c_x,
  output logic [maxWidthLen-1:0]        c_y,
  output logic signed [sizeValue-1:0]   c_out,
  output logic                          c_w
);

  localparam logic [maxWidthLen:0] MAXN = {1'b1, {maxWidthLen{1'b0}}};

  state_t                       r_state, w_state_nxt;
  logic [maxWidthLen-1:0]       r_i, r_j, r_k;
  logic [maxWidthLen-1:0]       w_i_nxt, w_j_nxt, w_k_nxt;
  logic [maxWidthLen:0]         r_n, w_n_nxt, w_dim_cl, w_n_m1;
  logic                         w_k_last, w_j_last, w_i_last;
  logic                         w_clr, w_acc_en;
  logic signed [sizeValue-1:0]  w_red, r_c_out;
  logic                         r_busy, r_done, r_c_w;

  assign w_dim_cl = (dim > MAXN) ? MAXN : dim;
  assign w_n_m1   = r_n - (maxWidthLen + 1)'(1);
  assign w_k_last = ({1'b0, r_k} == w_n_m1);
  assign w_j_last = ({1'b0, r_j} == w_n_m1);
  assign w_i_last = ({1'b0, r_i} == w_n_m1);

  matmul_mac #(
    .sizeValue (sizeValue),
    .accWidth  (accWidth)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_clr),
    .i_en  (w_acc_en),
    .i_a   (a_in),
    .i_b   (b_in),
    .o_red (w_red)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_i_nxt     = r_i;
    w_j_nxt     = r_j;
    w_k_nxt     = r_k;
    w_n_nxt     = r_n;
    w_clr       = 1'b0;
    w_acc_en    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_n_nxt     = w_dim_cl;
          w_i_nxt     = '0;
          w_j_nxt     = '0;
          w_k_nxt     = '0;
          w_clr       = 1'b1;
          w_state_nxt = (w_dim_cl == '0) ? FIN : ISSUE;
        end
      end
      ISSUE: begin
        // Data for k-1 arrives this cycle; the first ISSUE cycle has nothing yet.
        w_acc_en = (r_k != '0);
        if (w_k_last) begin
          w_state_nxt = DRAIN;
        end else begin
          w_k_nxt = r_k + maxWidthLen'(1);
        end
      end
      DRAIN: begin
        w_acc_en    = 1'b1;
        w_state_nxt = WRITE;
      end
      WRITE: begin
        w_clr   = 1'b1;
        w_k_nxt = '0;
        if (!w_j_last) begin
          w_j_nxt     = r_j + maxWidthLen'(1);
          w_state_nxt = ISSUE;
        end else if (!w_i_last) begin
          w_j_nxt     = '0;
          w_i_nxt     = r_i + maxWidthLen'(1);
          w_state_nxt = ISSUE;
        end else begin
          w_j_nxt     = '0;
          w_i_nxt     = '0;
          w_state_nxt = FIN;
        end
      end
      FIN:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_i     <= '0;
      r_j     <= '0;
      r_k     <= '0;
      r_n     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_c_w   <= 1'b0;
      r_c_out <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_i     <= w_i_nxt;
      r_j     <= w_j_nxt;
      r_k     <= w_k_nxt;
      r_n     <= w_n_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      r_done  <= (w_state_nxt == FIN);
      r_c_w   <= (w_state_nxt == WRITE);
      if (w_state_nxt == WRITE) begin
        r_c_out <= w_red;
      end
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign a_x   = r_i;
  assign a_y   = r_k;
  assign b_x   = r_k;
  assign b_y   = r_j;
  assign c_x   = r_i;
  assign c_y   = r_j;
  assign c_out = r_c_out;
  assign c_w   = r_c_w;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Bench for matmul_sequencer: memory models for A/B/C, write/done logging, reference matmul.
module tb_matmul_sequencer;

  localparam int MW   = 2;
  localparam int SV   = 8;
  localparam int MAXD = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic [MW:0]          dim = '0;
  logic                 busy, done, c_w;
  logic [MW-1:0]        a_x, a_y, b_x, b_y, c_x, c_y;
  logic signed [SV-1:0] a_in = '0;
  logic signed [SV-1:0] b_in = '0;
  logic signed [SV-1:0] c_out;

  always #5 clk = ~clk;

  matmul_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .dim   (dim),
    .busy  (busy),
    .done  (done),
    .a_x   (a_x),
    .a_y   (a_y),
    .a_in  (a_in),
    .b_x   (b_x),
    .b_y   (b_y),
    .b_in  (b_in),
    .c_x   (c_x),
    .c_y   (c_y),
    .c_out (c_out),
    .c_w   (c_w)
  );

  logic signed [SV-1:0] mem_a [MAXD][MAXD];
  logic signed [SV-1:0] mem_b [MAXD][MAXD];
  logic signed [SV-1:0] mem_c [MAXD][MAXD];

  always @(posedge clk) begin
    a_in <= mem_a[a_x][a_y];
    b_in <= mem_b[b_x][b_y];
    if (c_w) mem_c[c_x][c_y] <= c_out;
  end

  typedef struct {
    int t;
    int x;
    int y;
    int d;
  } wr_t;

  wr_t wq[$];
  int  cyc = 0;
  int  done_cnt = 0;
  int  done_t = 0;
  int  busy_cnt = 0;
  int  checks = 0;
  int  failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (c_w) wq.push_back('{cyc, int'(c_x), int'(c_y), int'(c_out)});
    if (done) begin
      done_cnt++;
      done_t = cyc;
    end
    if (busy) busy_cnt++;
  end

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_reduce(input int v);
`ifdef MATMUL_SATURATE_EN
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
`else
    logic signed [SV-1:0] t;
    t = SV'(v);
    return int'(t);
`endif
  endfunction

  function automatic int ref_elem(input int n, input int i, input int j);
    int acc = 0;
    for (int k = 0; k < n; k++) acc += int'(mem_a[i][k]) * int'(mem_b[k][j]);
    return ref_reduce(acc);
  endfunction

  task automatic fill_random();
    for (int i = 0; i < MAXD; i++)
      for (int j = 0; j < MAXD; j++) begin
        mem_a[i][j] = SV'($urandom);
        mem_b[i][j] = SV'($urandom);
      end
  endtask

  task automatic run_and_check(input string tag, input int d, input bit extra);
    int n, s0, d0, total;
    n     = (d > MAXD) ? MAXD : d;
    total = n * n * (n + 2) + 1;
    wq.delete();
    d0 = done_cnt;
    @(negedge clk);
    busy_cnt = 0;
    start = 1'b1;
    dim   = (MW + 1)'(d);
    s0    = cyc;
    @(negedge clk);
    dim = (MW + 1)'($urandom);
    if (!extra) begin
      start = 1'b0;
    end else begin
      repeat (3) @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int c = 0; c < total + 20 && done_cnt == d0; c++) @(negedge clk);
    repeat (3) @(negedge clk);
    check_val({tag, "_done_cnt"}, done_cnt - d0, 1);
    check_val({tag, "_done_time"}, done_t - s0, total);
    check_val({tag, "_busy_cycles"}, busy_cnt, total);
    check_val({tag, "_writes"}, wq.size(), n * n);
    for (int w = 0; w < wq.size() && w < n * n; w++) begin
      check_val({tag, "_wx"}, wq[w].x, w / n);
      check_val({tag, "_wy"}, wq[w].y, w % n);
      check_val({tag, "_wdata"}, wq[w].d, ref_elem(n, w / n, w % n));
      check_val({tag, "_wtime"}, wq[w].t - s0, (w + 1) * (n + 2));
    end
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++)
        check_val({tag, "_cmem"}, int'(mem_c[i][j]), ref_elem(n, i, j));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0;
    for (int i = 0; i < MAXD; i++)
      for (int j = 0; j < MAXD; j++) begin
        mem_a[i][j] = '0;
        mem_b[i][j] = '0;
      end
    repeat (3) @(negedge clk);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_done", int'(done), 0);
    check_val("rst_cw", int'(c_w), 0);
    check_val("rst_cout", int'(c_out), 0);
    check_val("rst_addr", int'({a_x, a_y, b_x, b_y, c_x, c_y}), 0);
    rst_n = 1'b1;

    mem_a[0][0] = 1; mem_a[0][1] = 2; mem_a[1][0] = 3; mem_a[1][1] = 4;
    mem_b[0][0] = 5; mem_b[0][1] = 6; mem_b[1][0] = 7; mem_b[1][1] = 8;
    run_and_check("mm2", 2, 1'b0);
    if (wq.size() == 4) begin
      check_val("mm2_c00", wq[0].d, 19);
      check_val("mm2_c01", wq[1].d, 22);
      check_val("mm2_c10", wq[2].d, 43);
      check_val("mm2_c11", wq[3].d, 50);
      check_val("mm2_spacing", wq[3].t - wq[2].t, 4);
    end else begin
      check_val("mm2_wcount", wq.size(), 4);
    end

    mem_a[0][0] = -3;
    mem_b[0][0] = 5;
    run_and_check("mm1", 1, 1'b0);
    if (wq.size() == 1) check_val("mm1_val", wq[0].d, -15);

    run_and_check("mm0", 0, 1'b0);

    fill_random();
    for (int i = 0; i < MAXD; i++)
      for (int j = 0; j < MAXD; j++) mem_b[i][j] = (i == j) ? SV'(1) : SV'(0);
    run_and_check("ident", 4, 1'b1);
    for (int i = 0; i < MAXD; i++)
      for (int j = 0; j < MAXD; j++)
        check_val("ident_c_eq_a", int'(mem_c[i][j]), int'(mem_a[i][j]));

    for (int i = 0; i < MAXD; i++)
      for (int j = 0; j < MAXD; j++) begin
        mem_a[i][j] = 100;
        mem_b[i][j] = 100;
      end
    run_and_check("sat", 2, 1'b0);
`ifdef MATMUL_SATURATE_EN
    if (wq.size() > 0) check_val("sat_value", wq[0].d, 127);
`else
    if (wq.size() > 0) check_val("wrap_value", wq[0].d, 32);
`endif

    fill_random();
    wq.delete();
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    dim   = 3'd3;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 200 && wq.size() < 3; c++) @(negedge clk);
    check_val("midrst_reached_3_writes", int'(wq.size() >= 3), 1);
    rst_n = 1'b0;
    #1;
    check_val("midrst_busy", int'(busy), 0);
    check_val("midrst_cw", int'(c_w), 0);
    check_val("midrst_done", int'(done), 0);
    check_val("midrst_cout", int'(c_out), 0);
    check_val("midrst_addr", int'({a_x, a_y, b_x, b_y, c_x, c_y}), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_val("midrst_no_done", done_cnt - d0, 0);
    run_and_check("after_rst", 3, 1'b0);

    for (int r = 0; r < 6; r++) begin
      fill_random();
      run_and_check("rand", int'($urandom_range(0, 7)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
